// File: rtl/cpld_bus_ctrl_if.sv
// Host CPLD bus and register-file side signals of cpld_bus_ctrl.
// The master modport is the controller; the slave modport is its environment
// (pad buffer plus register file).
interface cpld_bus_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              ale;
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [DATA_W-1:0] reg_rdata;
  logic              reg_rvalid;

  modport master (
    input  ale, rd, wr, bus_in, reg_rdata, reg_rvalid,
    output bus_out, bus_oe, reg_addr, reg_wdata, reg_we, reg_re
  );

  modport slave (
    output ale, rd, wr, bus_in, reg_rdata, reg_rvalid,
    input  bus_out, bus_oe, reg_addr, reg_wdata, reg_we, reg_re
  );
endinterface

// File: rtl/cpld_bus_ctrl.sv
// Front end for the multiplexed host CPLD bus: synchronises ALE/RD/WR and the
// bus pads, latches the address phase, turns host accesses into one-cycle
// register-file strobes and owns the pad driver enable.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no read outstanding; writes and reads are accepted here
// RD_WAIT  | reg_re issued, waiting for reg_rvalid or the timeout
// RD_DRIVE | read data on the pads while the host keeps RD high
module cpld_bus_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 16,
  parameter int AUTO_INC    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  cpld_bus_ctrl_if.master cbus,
  output logic            busy,
  output logic            err_timeout,
  output logic            err_proto,
  input  logic            err_clr
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_DRIVE = 2'd2
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   abort_q;

  logic [SYNC_STAGES-1:0] ale_sync;
  logic [SYNC_STAGES-1:0] rd_sync;
  logic [SYNC_STAGES-1:0] wr_sync;
  logic [DATA_W-1:0]      bus_sync [SYNC_STAGES];
  logic                   ale_d;
  logic                   rd_d;
  logic                   wr_d;

  logic                   ale_s;
  logic                   rd_s;
  logic                   wr_s;
  logic [DATA_W-1:0]      bus_s;
  logic                   ale_rise;
  logic                   rd_rise;
  logic                   rd_fall;
  logic                   wr_rise;

  logic                   wr_go;
  logic                   rd_go;
  logic                   proto_set;
  logic                   timeout_hit;
  logic                   wait_end;
  logic                   rd_done;

  assign ale_s    = ale_sync[SYNC_STAGES-1];
  assign rd_s     = rd_sync[SYNC_STAGES-1];
  assign wr_s     = wr_sync[SYNC_STAGES-1];
  assign bus_s    = bus_sync[SYNC_STAGES-1];
  assign ale_rise = ale_s & ~ale_d;
  assign rd_rise  = rd_s & ~rd_d;
  assign rd_fall  = ~rd_s & rd_d;
  assign wr_rise  = wr_s & ~wr_d;
  assign busy     = (state != IDLE);

  // Synchronise host strobes and bus pads with equal depth so data lines up with edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ale_sync <= '0;
      rd_sync  <= '0;
      wr_sync  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) bus_sync[i] <= '0;
      ale_d    <= 1'b0;
      rd_d     <= 1'b0;
      wr_d     <= 1'b0;
    end else begin
      ale_sync    <= {ale_sync[SYNC_STAGES-2:0], cbus.ale};
      rd_sync     <= {rd_sync[SYNC_STAGES-2:0], cbus.rd};
      wr_sync     <= {wr_sync[SYNC_STAGES-2:0], cbus.wr};
      bus_sync[0] <= cbus.bus_in;
      for (int i = 1; i < SYNC_STAGES; i++) bus_sync[i] <= bus_sync[i-1];
      ale_d       <= ale_s;
      rd_d        <= rd_s;
      wr_d        <= wr_s;
    end
  end

  // Arbitrate coincident strobe edges and detect the end of the read wait.
  always_comb begin
    proto_set   = (ale_rise & (rd_rise | wr_rise)) | (rd_rise & wr_rise)
                | (wr_rise & (state != IDLE));
    wr_go       = (state == IDLE) & wr_rise & ~rd_rise & ~ale_rise;
    rd_go       = (state == IDLE) & rd_rise & ~wr_rise & ~ale_rise;
    timeout_hit = (state == RD_WAIT) & ~cbus.reg_rvalid & (cnt == CNT_W'(TIMEOUT));
    wait_end    = (state == RD_WAIT) & (cbus.reg_rvalid | (cnt == CNT_W'(TIMEOUT)));
    rd_done     = (wait_end & (abort_q | rd_fall)) | ((state == RD_DRIVE) & rd_fall);
  end

  // Access sequencer: write strobe, read request, wait/timeout and pad drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      abort_q        <= 1'b0;
      cbus.reg_we    <= 1'b0;
      cbus.reg_re    <= 1'b0;
      cbus.reg_wdata <= '0;
      cbus.bus_oe    <= 1'b0;
      cbus.bus_out   <= '0;
    end else begin
      cbus.reg_we <= 1'b0;
      cbus.reg_re <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_go) begin
            cbus.reg_wdata <= bus_s;
            cbus.reg_we    <= 1'b1;
          end else if (rd_go) begin
            cbus.reg_re <= 1'b1;
            cnt         <= '0;
            abort_q     <= 1'b0;
            state       <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rd_fall) abort_q <= 1'b1;
          if (wait_end) begin
            // A host that already let go of RD never sees the data.
            if (abort_q | rd_fall) begin
              state <= IDLE;
            end else begin
              state        <= RD_DRIVE;
              cbus.bus_oe  <= 1'b1;
              cbus.bus_out <= cbus.reg_rvalid ? cbus.reg_rdata : '1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RD_DRIVE: begin
          if (rd_fall) begin
            state        <= IDLE;
            cbus.bus_oe  <= 1'b0;
            cbus.bus_out <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address latch; a new address phase takes precedence over auto-increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cbus.reg_addr <= '0;
    end else if (ale_rise) begin
      cbus.reg_addr <= bus_s[ADDR_W-1:0];
    end else if ((AUTO_INC != 0) && (cbus.reg_we || rd_done)) begin
      cbus.reg_addr <= cbus.reg_addr + ADDR_W'(1);
    end
  end

  // Sticky error flags; a set event in the same cycle beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
      err_proto   <= 1'b0;
    end else begin
      err_timeout <= (err_timeout & ~err_clr) | timeout_hit;
      err_proto   <= (err_proto & ~err_clr) | proto_set;
    end
  end
endmodule

// File: tb/tb_cpld_bus_ctrl.sv
// Scoreboard bench for cpld_bus_ctrl: one instance without and one with
// address auto-increment, driven by the same host and register-file stimulus.
module tb_cpld_bus_ctrl;
  localparam int TO  = 16;
  localparam int LAT = 3;  // two sync stages plus the registered strobe

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ale = 1'b0, rd = 1'b0, wr = 1'b0, err_clr = 1'b0, reg_rvalid = 1'b0;
  logic [7:0] bus_in = 8'h00, reg_rdata = 8'h00;
  int         cyc = 0;
  int         vectors = 0, miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpld_bus_ctrl_if #(.DATA_W(8), .ADDR_W(8)) ifa ();
  cpld_bus_ctrl_if #(.DATA_W(8), .ADDR_W(8)) ifb ();

  assign ifa.ale = ale;         assign ifb.ale = ale;
  assign ifa.rd = rd;           assign ifb.rd = rd;
  assign ifa.wr = wr;           assign ifb.wr = wr;
  assign ifa.bus_in = bus_in;   assign ifb.bus_in = bus_in;
  assign ifa.reg_rdata = reg_rdata;   assign ifb.reg_rdata = reg_rdata;
  assign ifa.reg_rvalid = reg_rvalid; assign ifb.reg_rvalid = reg_rvalid;

  logic busy_a, busy_b, et_a, et_b, ep_a, ep_b;

  cpld_bus_ctrl #(.DATA_W(8), .ADDR_W(8), .SYNC_STAGES(2), .TIMEOUT(TO), .AUTO_INC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cbus(ifa.master), .busy(busy_a),
    .err_timeout(et_a), .err_proto(ep_a), .err_clr(err_clr));

  cpld_bus_ctrl #(.DATA_W(8), .ADDR_W(8), .SYNC_STAGES(2), .TIMEOUT(TO), .AUTO_INC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cbus(ifb.master), .busy(busy_b),
    .err_timeout(et_b), .err_proto(ep_b), .err_clr(err_clr));

  logic [1:0] we_m, re_m, oe_m, busy_m, et_m, ep_m;
  logic [7:0] addr_m [2], wdata_m [2], out_m [2];
  assign we_m = {ifb.reg_we, ifa.reg_we};
  assign re_m = {ifb.reg_re, ifa.reg_re};
  assign oe_m = {ifb.bus_oe, ifa.bus_oe};
  assign busy_m = {busy_b, busy_a};
  assign et_m = {et_b, et_a};
  assign ep_m = {ep_b, ep_a};
  assign addr_m[0] = ifa.reg_addr;   assign addr_m[1] = ifb.reg_addr;
  assign wdata_m[0] = ifa.reg_wdata; assign wdata_m[1] = ifb.reg_wdata;
  assign out_m[0] = ifa.bus_out;     assign out_m[1] = ifb.bus_out;

  typedef struct packed { logic [7:0] addr; logic [7:0] data; int cyc; } wr_exp_t;
  typedef struct packed { logic [7:0] val; int rise; int fall; } drv_exp_t;
  typedef struct packed { logic resp; int dly; logic [7:0] data; } rsp_t;

  wr_exp_t  wq [2][$];
  int       rq [2][$];
  drv_exp_t dq [2][$];
  rsp_t     rspq [$];

  // reference model: address latch per instance and the sticky flags
  logic [7:0] mdl_addr [2];
  logic       mdl_et = 1'b0, mdl_ep = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pops scoreboard entries whenever a DUT presents a strobe or drive
  initial begin
    wr_exp_t  we_e;
    drv_exp_t cur [2];
    logic     oe_prev [2];
    int       rc;
    oe_prev[0] = 1'b0; oe_prev[1] = 1'b0;
    cur[0] = '0; cur[1] = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          oe_prev[i] = 1'b0;
        end else begin
          if (we_m[i]) begin
            chk($sformatf("we_expected%0d", i), wq[i].size() != 0, 1);
            if (wq[i].size() != 0) begin
              we_e = wq[i].pop_front();
              chk($sformatf("we_addr%0d", i), addr_m[i], we_e.addr);
              chk($sformatf("we_data%0d", i), wdata_m[i], we_e.data);
              chk($sformatf("we_cycle%0d", i), cyc, we_e.cyc);
            end
          end
          if (re_m[i]) begin
            chk($sformatf("re_expected%0d", i), rq[i].size() != 0, 1);
            if (rq[i].size() != 0) begin
              rc = rq[i].pop_front();
              chk($sformatf("re_cycle%0d", i), cyc, rc);
            end
          end
          if (oe_m[i] && !oe_prev[i]) begin
            chk($sformatf("oe_expected%0d", i), dq[i].size() != 0, 1);
            if (dq[i].size() != 0) begin
              cur[i] = dq[i].pop_front();
              chk($sformatf("oe_rise_cycle%0d", i), cyc, cur[i].rise);
            end
          end
          if (!oe_m[i] && oe_prev[i]) chk($sformatf("oe_fall_cycle%0d", i), cyc, cur[i].fall);
          if (oe_m[i]) chk($sformatf("bus_out_drive%0d", i), out_m[i], cur[i].val);
          else         chk($sformatf("bus_out_idle%0d", i), out_m[i], 8'h00);
          oe_prev[i] = oe_m[i];
        end
      end
    end
  end

  // register-file responder: answers each reg_re according to the planned response
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst_n && re_m[0] && rspq.size() != 0) begin
        r = rspq.pop_front();
        if (r.resp) begin
          repeat (r.dly) @(negedge clk);
          reg_rdata  = r.data;
          reg_rvalid = 1'b1;
          @(negedge clk);
          reg_rvalid = 1'b0;
          reg_rdata  = 8'($urandom);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic settle_check();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("busy_idle%0d", i), busy_m[i], 0);
      chk($sformatf("err_timeout%0d", i), et_m[i], mdl_et);
      chk($sformatf("err_proto%0d", i), ep_m[i], mdl_ep);
      chk($sformatf("reg_addr%0d", i), addr_m[i], mdl_addr[i]);
      chk($sformatf("pending_we%0d", i), wq[i].size(), 0);
      chk($sformatf("pending_re%0d", i), rq[i].size(), 0);
      chk($sformatf("pending_drive%0d", i), dq[i].size(), 0);
    end
  endtask

  task automatic ale_cycle(input logic [7:0] a);
    @(negedge clk);
    bus_in = a;
    ale = 1'b1;
    repeat (4) @(negedge clk);
    ale = 1'b0;
    repeat (3) @(negedge clk);
    mdl_addr[0] = a;
    mdl_addr[1] = a;
    settle_check();
  endtask

  task automatic do_write(input logic [7:0] d);
    wr_exp_t e;
    @(negedge clk);
    bus_in = d;
    wr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      e.addr = mdl_addr[i]; e.data = d; e.cyc = cyc + LAT;
      wq[i].push_back(e);
    end
    repeat (4) @(negedge clk);
    wr = 1'b0;
    repeat (4) @(negedge clk);
    mdl_addr[1] = mdl_addr[1] + 8'd1;
    settle_check();
  endtask

  task automatic do_read(input logic resp, input int dly, input logic [7:0] data,
                         input logic early, input logic wr_inject);
    int c, dd, hold;
    drv_exp_t e;
    rsp_t r;
    @(negedge clk);
    c    = cyc;
    dd   = resp ? dly : TO;
    hold = early ? 3 : dd + 3 + int'($urandom_range(1, 5));
    r.resp = resp; r.dly = dly; r.data = data;
    rspq.push_back(r);
    for (int i = 0; i < 2; i++) begin
      rq[i].push_back(c + LAT);
      if (!early) begin
        e.val = resp ? data : 8'hFF; e.rise = c + LAT + 1 + dd; e.fall = c + hold + LAT;
        dq[i].push_back(e);
      end
    end
    rd = 1'b1;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      if (k == 3) for (int i = 0; i < 2; i++) chk($sformatf("busy_read%0d", i), busy_m[i], 1);
      if (wr_inject && k == 4) wr = 1'b1;
      if (wr_inject && k == 7) wr = 1'b0;
    end
    rd = 1'b0;
    repeat (early ? dd + 6 : 5) @(negedge clk);
    if (!resp) mdl_et = 1'b1;
    if (wr_inject) mdl_ep = 1'b1;
    mdl_addr[1] = mdl_addr[1] + 8'd1;
    settle_check();
  endtask

  task automatic do_proto(input int kind, input logic [7:0] a);
    @(negedge clk);
    bus_in = a;
    case (kind)
      0:       begin rd = 1'b1;  wr = 1'b1; end
      1:       begin ale = 1'b1; wr = 1'b1; end
      default: begin ale = 1'b1; rd = 1'b1; end
    endcase
    repeat (4) @(negedge clk);
    ale = 1'b0; rd = 1'b0; wr = 1'b0;
    repeat (4) @(negedge clk);
    if (kind != 0) begin mdl_addr[0] = a; mdl_addr[1] = a; end
    mdl_ep = 1'b1;
    settle_check();
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    mdl_et = 1'b0;
    mdl_ep = 1'b0;
    settle_check();
  endtask

  initial begin
    int       c, sel, dly;
    rsp_t     r;
    drv_exp_t e;
    mdl_addr[0] = 8'h00;
    mdl_addr[1] = 8'h00;

    #12;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_reg_addr%0d", i), addr_m[i], 8'h00);
      chk($sformatf("rst_reg_wdata%0d", i), wdata_m[i], 8'h00);
      chk($sformatf("rst_reg_we%0d", i), we_m[i], 0);
      chk($sformatf("rst_reg_re%0d", i), re_m[i], 0);
      chk($sformatf("rst_bus_oe%0d", i), oe_m[i], 0);
      chk($sformatf("rst_bus_out%0d", i), out_m[i], 8'h00);
      chk($sformatf("rst_busy%0d", i), busy_m[i], 0);
      chk($sformatf("rst_err_timeout%0d", i), et_m[i], 0);
      chk($sformatf("rst_err_proto%0d", i), ep_m[i], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    ale_cycle(8'h05);
    do_write(8'hA7);
    ale_cycle(8'h02);
    do_read(1'b1, 3, 8'h3C, 1'b0, 1'b0);
    do_read(1'b0, 0, 8'h00, 1'b0, 1'b0);
    clr_pulse();
    do_read(1'b1, 0, 8'h96, 1'b0, 1'b0);
    do_read(1'b1, TO, 8'h69, 1'b0, 1'b0);
    ale_cycle(8'hFE);
    do_write(8'h11);
    do_write(8'h22);
    do_write(8'h33);
    do_proto(0, 8'h00);
    do_read(1'b1, 6, 8'h5A, 1'b0, 1'b1);
    do_read(1'b1, 10, 8'hC3, 1'b1, 1'b0);
    do_read(1'b0, 0, 8'h00, 1'b1, 1'b0);

    // reset while the pads are being driven
    @(negedge clk);
    c = cyc;
    r.resp = 1'b1; r.dly = 2; r.data = 8'hE4;
    rspq.push_back(r);
    for (int i = 0; i < 2; i++) begin
      rq[i].push_back(c + LAT);
      e.val = 8'hE4; e.rise = c + LAT + 1 + 2; e.fall = -1;
      dq[i].push_back(e);
    end
    rd = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("drive_before_rst%0d", i), oe_m[i], 1);
      chk($sformatf("busy_before_rst%0d", i), busy_m[i], 1);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("async_rst_oe%0d", i), oe_m[i], 0);
      chk($sformatf("async_rst_busy%0d", i), busy_m[i], 0);
      chk($sformatf("async_rst_bus_out%0d", i), out_m[i], 8'h00);
    end
    @(negedge clk);
    rd = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mdl_addr[0] = 8'h00; mdl_addr[1] = 8'h00;
    mdl_et = 1'b0; mdl_ep = 1'b0;
    repeat (2) @(negedge clk);
    settle_check();
    ale_cycle(8'h01);
    do_write(8'h4D);

    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1:    ale_cycle(8'($urandom));
        2, 3, 4: do_write(8'($urandom));
        5, 6:    do_read($urandom_range(0, 5) != 0, int'($urandom_range(0, TO)),
                         8'($urandom), 1'b0, 1'b0);
        7: begin
          dly = int'($urandom_range(8, TO));
          do_read($urandom_range(0, 3) != 0, dly, 8'($urandom), 1'b1, 1'b0);
        end
        8: begin
          if ($urandom_range(0, 1) == 0) do_proto(int'($urandom_range(0, 2)), 8'($urandom));
          else do_read(1'b1, int'($urandom_range(4, TO)), 8'($urandom), 1'b0, 1'b1);
        end
        default: clr_pulse();
      endcase
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cpld_bus_ctrl.md
Name: cpld_bus_ctrl

Overview:
Clocked front-end controller for the host multiplexed 8-bit CPLD bus with ALE/RD/WR strobes. It synchronises the asynchronous host strobes and latches the address phase. It sequences each access into single-cycle register-file strobes, and it owns the bus output driver and its enable. It sits between the pad-level tristate buffer and the internal register file.

Parameters:
DATA_W, 8, bus and register data width
ADDR_W, 8, latched address width (low ADDR_W bits of bus at ALE)
SYNC_STAGES, 2, flip-flop stages on ale/rd/wr/bus_in (>=2)
TIMEOUT, 16, max clk cycles waiting for reg_rvalid after reg_re
AUTO_INC, 0, 1 = increment latched address after every completed access

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ale  input  1  host address latch enable, async, active high
rd  input  1  host read strobe, async, active high
wr  input  1  host write strobe, async, active high
bus_in  input  DATA_W  pad input of cpldbus, async
bus_out  output  DATA_W  value for pad driver
bus_oe  output  1  pad driver enable (1 = drive cpldbus)
reg_addr  output  ADDR_W  latched access address
reg_wdata  output  DATA_W  write data to register file
reg_we  output  1  one-cycle write strobe
reg_re  output  1  one-cycle read request
reg_rdata  input  DATA_W  read data from register file
reg_rvalid  input  1  reg_rdata valid, one-cycle pulse, 0..TIMEOUT cycles after reg_re
busy  output  1  read in progress (state != IDLE)
err_timeout  output  1  sticky: a read timed out
err_proto  output  1  sticky: illegal strobe combination seen
err_clr  input  1  synchronous clear of both sticky errors

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Reset drives all outputs to 0 and the state to IDLE, and clears all synchroniser flops.
- Synchronisation: ale, rd, wr and bus_in pass through SYNC_STAGES flops. Edge detect uses the last stage against a one-cycle-delayed copy. bus_in is sampled through the same depth, so data aligns with the strobe edges.
- ALE rise (any state): reg_addr <= synced bus_in[ADDR_W-1:0] on the cycle after the edge.
- IDLE, WR rise: reg_wdata <= synced bus_in. reg_we pulses for exactly 1 cycle, 1 cycle after the edge, using the current reg_addr.
- IDLE, RD rise: reg_re pulses 1 cycle and the FSM enters RD_WAIT.
- RD_WAIT:
  - The counter counts from 0.
  - If reg_rvalid arrives: capture reg_rdata into the output register and go to RD_DRIVE.
  - If the counter reaches TIMEOUT with no rvalid: output register <= all ones, set err_timeout, go to RD_DRIVE.
- RD_DRIVE: bus_oe = 1 and bus_out = output register while synced rd is high. On synced rd fall, bus_oe = 0 the next cycle and the FSM returns to IDLE.
- Early RD fall in RD_WAIT: bus_oe is never asserted. The FSM finishes the wait (rvalid or timeout) and discards the data, then returns to IDLE. The access still counts as completed.
- bus_oe: asserted only in RD_DRIVE with synced rd = 1. bus_out = 0 whenever bus_oe = 0.
- AUTO_INC = 1: reg_addr increments by 1, modulo 2^ADDR_W (0xFF wraps to 0x00), on the cycle after reg_we, or on return to IDLE from RD_DRIVE/early-fall.
- Simultaneous events:
  - ALE rise with RD or WR rise in the same cycle: ALE is processed, RD/WR is ignored, err_proto is set.
  - RD and WR rise together: both are ignored, err_proto is set.
  - WR rise outside IDLE: ignored, err_proto is set.
  - ALE rise in RD_WAIT/RD_DRIVE: address updates, and the current read continues.
- err_clr: clears both sticky flags. A same-cycle set event wins over clear.
- busy = (state != IDLE).

Test Plan:
- Write access: reset, ALE with bus=0x05, then WR with bus=0xA7 -> single reg_we pulse with reg_addr=0x05, reg_wdata=0xA7, 1 cycle after the synced WR edge; no reg_re; bus_oe stays 0.
- Read access: ALE with 0x02, RD high, model returns rvalid 3 cycles after reg_re with 0x3C -> bus_oe=1, bus_out=0x3C until the synced RD fall; bus_oe=0 one cycle after the fall; busy returns to 0.
- Timeout: read with no rvalid -> after 16 cycles bus_out=0xFF, err_timeout=1; err_clr pulse -> err_timeout=0.
- Auto-increment and wrap (AUTO_INC=1): ALE 0xFE, then three writes 0x11/0x22/0x33 -> reg_we addresses 0xFE, 0xFF, 0x00.
- Protocol errors: RD and WR rising together -> no reg_re/reg_we, err_proto=1. WR during RD_WAIT -> ignored, err_proto stays 1, the read completes normally.
- Reset mid-read: assert rst_n=0 during RD_DRIVE -> bus_oe, busy and bus_out drop to 0 immediately (asynchronously). After release, a fresh write to 0x01 works normally.
